uart_tx_sender: RTL

- Downstream of the UART TX mode FSM.
- Consumes the one-hot mode flags (INITIAL / NORMAL / START_CONTROL), the ASCII rate code and the payload byte.
- In NORMAL mode, periodically serialises the payload as 8N1 frames on the TX line, at a frame-repeat rate selected by the rate code.
- In all other modes the line idles high.

---
 rtl/uart_tx_sender_if.sv | 16 +
 rtl/uart_tx_sender.sv | 127 ++++++++++++
 2 files changed

// File: rtl/uart_tx_sender_if.sv
// Mode, rate and payload inputs of the periodic UART sender, plus its serial line and status outputs.
interface uart_tx_sender_if;
  logic       iTX_INITIAL;
  logic       iTX_NORMAL;
  logic       iTX_START_CONTROL;
  logic [7:0] iTX_rate;
  logic [7:0] idata;
  logic       oTX;
  logic       oBUSY;
  logic       oDONE;

  modport master (output iTX_INITIAL, iTX_NORMAL, iTX_START_CONTROL, iTX_rate, idata,
                  input  oTX, oBUSY, oDONE);
  modport slave  (input  iTX_INITIAL, iTX_NORMAL, iTX_START_CONTROL, iTX_rate, idata,
                  output oTX, oBUSY, oDONE);
endinterface

// File: rtl/uart_tx_sender.sv
// Periodic 8N1 sender: in NORMAL mode a 100 ms tick scheduler requests frames at the rate the
// ASCII code selects, and a START/DATA/STOP FSM serialises the payload latched at launch.
module uart_tx_sender #(
  parameter int CLKS_PER_BIT   = 5208,
  parameter int CLKS_PER_100MS = 5000000
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_sender_if.slave  bus
);
  localparam int TW = $clog2(CLKS_PER_100MS);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TICK_MAX = TW'(CLKS_PER_100MS - 1);
  localparam logic [BW-1:0] BIT_MAX  = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic          normal;
  logic          normal_d, wrap_q, pending, pending_n;
  logic [3:0]    n_dec, n_q, ivl;
  logic [TW-1:0] tick;
  logic          rise, change, req, launch, done;
  state_t        state, state_n;
  logic [BW-1:0] cnt, cnt_n;
  logic [2:0]    bitn, bitn_n;
  logic [7:0]    sh, sh_n;
  logic          unused_flags;

  assign normal       = bus.iTX_NORMAL;
  assign unused_flags = ^{bus.iTX_INITIAL, bus.iTX_START_CONTROL};

  always_comb begin
    case (bus.iTX_rate)
      8'h35:   n_dec = 4'd2;
      8'h61:   n_dec = 4'd1;
      default: n_dec = 4'd10;
    endcase
  end

  // The cycle that starts an interval (NORMAL rise or rate change) counts as tick position 0,
  // and the wrap is registered so requests land exactly N*CLKS_PER_100MS cycles after it.
  assign rise   = normal & ~normal_d;
  assign change = normal & normal_d & (n_dec != n_q);
  assign req    = rise | (normal & wrap_q & ~change);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      normal_d <= 1'b0;
      n_q      <= 4'd10;
      wrap_q   <= 1'b0;
      tick     <= '0;
      ivl      <= '0;
    end else begin
      normal_d <= normal;
      n_q      <= n_dec;
      wrap_q   <= normal & ~change & (tick == TICK_MAX) & (ivl == 4'(n_q - 4'd1));
      if (!normal) begin
        tick <= '0;
        ivl  <= '0;
      end else if (change) begin
        tick <= TW'(1);
        ivl  <= '0;
      end else if (tick == TICK_MAX) begin
        tick <= '0;
        ivl  <= (ivl == 4'(n_q - 4'd1)) ? 4'd0 : ivl + 4'd1;
      end else begin
        tick <= tick + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bitn    <= '0;
      sh      <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bitn    <= bitn_n;
      sh      <= sh_n;
      pending <= pending_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bitn_n  = bitn;
    sh_n    = sh;
    launch  = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: if (pending && normal) begin
        state_n = START;
        sh_n    = bus.idata;
        cnt_n   = '0;
        bitn_n  = '0;
        launch  = 1'b1;
      end
      START: if (cnt == BIT_MAX) begin
        cnt_n   = '0;
        state_n = DATA;
      end else cnt_n = cnt + 1'b1;
      DATA: if (cnt == BIT_MAX) begin
        cnt_n = '0;
        sh_n  = {1'b0, sh[7:1]};
        if (bitn == 3'd7) state_n = STOP;
        else              bitn_n  = bitn + 3'd1;
      end else cnt_n = cnt + 1'b1;
      STOP: if (cnt == BIT_MAX) begin
        cnt_n   = '0;
        done    = 1'b1;
        state_n = IDLE;
      end else cnt_n = cnt + 1'b1;
      default: state_n = IDLE;
    endcase
    // A request landing while one is already pending (including the launch cycle) is dropped.
    pending_n = normal & ~launch & (pending | req);
  end

  assign bus.oTX   = (state == START) ? 1'b0 : (state == DATA) ? sh[0] : 1'b1;
  assign bus.oBUSY = (state != IDLE);
  assign bus.oDONE = done;
endmodule
